// File: rtl/apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// apb_master_ctrl
//
// APB3 requester. Converts a valid/ready command stream into APB transfers
// and returns exactly one response pulse per accepted command. A command
// offered in the completion cycle of the current transfer is accepted on the
// same edge, so back-to-back transfers keep PSEL high with no IDLE bubble.
//
// Optional feature (compile-time macro APB_MASTER_TIMEOUT_EN):
//   When defined, a transfer whose ACCESS phase sees PREADY low for
//   TIMEOUT_CYCLES cycles is aborted and answered with rsp_timeout=1.
//   When undefined, ACCESS waits for PREADY indefinitely and rsp_timeout
//   stays 0.
//
// Ports:
//   PCLK        bus clock, all state on its rising edge
//   PRESET      synchronous active-high reset
//   cmd_valid   command present
//   cmd_ready   command accepted on an edge where cmd_valid && cmd_ready
//   cmd_addr    target address
//   cmd_write   1 = write, 0 = read
//   cmd_wdata   write data
//   rsp_valid   one-cycle response pulse per accepted command
//   rsp_rdata   PRDATA captured on completion (0 for writes and timeouts)
//   rsp_timeout qualifies rsp_valid: transfer was aborted
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA   registered APB requester outputs
//   PRDATA, PREADY                         APB completer inputs
// -----------------------------------------------------------------------------
module apb_master_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0] r_state;
  logic       w_accept;
  logic       w_done;
  logic       w_abort;

  // Ready in IDLE, or in the ACCESS cycle that completes; this is what lets a
  // new command overlap the completion edge of the current one.
  assign cmd_ready = !PRESET &&
                     ((r_state == ST_IDLE) || ((r_state == ST_ACCESS) && PREADY));
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_done    = (r_state == ST_ACCESS) && PREADY;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  // Counts PREADY-low ACCESS cycles of the current transfer.
  logic [CNT_W-1:0] r_wait_cnt;

  // Abort on the edge where this low cycle would be the TIMEOUT_CYCLES-th.
  assign w_abort = (r_state == ST_ACCESS) && !PREADY && (r_wait_cnt == CNT_LAST);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      // Every accept enters SETUP, so this is the clear-on-SETUP-entry point.
      r_wait_cnt <= '0;
    end else if ((r_state == ST_ACCESS) && !PREADY && (r_wait_cnt != CNT_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;

      if (w_done) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= PWRITE ? '0 : PRDATA;
      end else if (w_abort) begin
        rsp_valid   <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end

      // Address/control/data change only on accept, so they are stable for
      // the whole transfer and hold their last value while idle.
      if (w_accept) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SETUP;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
          end
        end
        ST_SETUP: begin
          r_state <= ST_ACCESS;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          if (w_accept) begin
            // Back-to-back: PSEL stays high, PENABLE drops for the new SETUP.
            r_state <= ST_SETUP;
            PENABLE <= 1'b0;
          end else if (w_done || w_abort) begin
            r_state <= ST_IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_apb_master_ctrl
//
// Self-checking bench for apb_master_ctrl. A transaction-level reference model
// tracks the outstanding command and the APB phase it must be in, and predicts
// the bus outputs, cmd_ready and the response for every cycle. Directed
// sequences cover the documented scenarios; randomized traffic follows.
// -----------------------------------------------------------------------------
module tb_apb_master_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int TO     = 16;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  int n_tests = 0;
  int n_fail  = 0;

  apb_master_ctrl #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PADDR      (PADDR),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY)
  );

  always #5 PCLK = ~PCLK;

  // Completer memory: read data returned for PADDR[3:0].
  logic [31:0] mem [16];

  // Reference model: predicted outputs for the current cycle.
  logic        m_psel, m_pen, m_write, m_rv, m_rto;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int          m_waits;
  int          n_acc, n_drop, dut_rsp;

  // Observations of the last stepped cycle, used by directed checks.
  logic        obs_psel, obs_pen, obs_rv, obs_rto, obs_ready;
  logic [31:0] obs_paddr, obs_pwdata, obs_rdata;
  logic [7:0]  h_sel, h_en, h_rv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_psel  = 1'b0;
    m_pen   = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_rv    = 1'b0;
    m_rto   = 1'b0;
    m_rdata = '0;
    m_waits = 0;
  endtask

  task automatic hist_clear();
    h_sel = '0;
    h_en  = '0;
    h_rv  = '0;
  endtask

  // One bus cycle: check registered outputs, drive inputs, check cmd_ready,
  // then advance the model to what the next edge must produce.
  task automatic step(input logic v, input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic rdy, input logic rst);
    logic exp_ready, cpl, acc, abort, n_psel, n_pen;
    @(negedge PCLK);
    obs_psel   = PSEL;
    obs_pen    = PENABLE;
    obs_rv     = rsp_valid;
    obs_rto    = rsp_timeout;
    obs_rdata  = rsp_rdata;
    obs_paddr  = PADDR;
    obs_pwdata = PWDATA;
    h_sel = {h_sel[6:0], PSEL};
    h_en  = {h_en[6:0], PENABLE};
    h_rv  = {h_rv[6:0], rsp_valid};
    if (rsp_valid === 1'b1) dut_rsp++;
    chk("psel", 32'(PSEL), 32'(m_psel));
    chk("penable", 32'(PENABLE), 32'(m_pen));
    chk("paddr", PADDR, m_addr);
    chk("pwrite", 32'(PWRITE), 32'(m_write));
    chk("pwdata", PWDATA, m_wdata);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_timeout", 32'(rsp_timeout), 32'(m_rto));
    chk("rsp_rdata", rsp_rdata, m_rdata);

    PRESET    = rst;
    cmd_valid = v;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    PREADY    = rdy;
    PRDATA    = PSEL ? mem[PADDR[3:0]] : $urandom;
    #2;
    exp_ready = !rst && (!m_psel || (m_pen && rdy));
    obs_ready = cmd_ready;
    chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));

    if (rst) begin
      if (m_psel) n_drop++;
      model_reset();
    end else begin
      cpl   = m_psel && m_pen && rdy;
      abort = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      abort = m_psel && m_pen && !rdy && (m_waits + 1 == TO);
`endif
      acc   = v && exp_ready;
      m_rv  = cpl || abort;
      m_rto = abort;
      if (cpl) m_rdata = m_write ? 32'h0 : mem[m_addr[3:0]];
      if (abort) m_rdata = 32'h0;
      if (m_psel && m_pen && !rdy) m_waits++;
      n_pen  = m_psel && !cpl && !abort;
      n_psel = acc || (m_psel && !cpl && !abort);
      m_psel = n_psel;
      m_pen  = n_pen;
      if (acc) begin
        m_addr  = a;
        m_write = w;
        m_wdata = d;
        m_waits = 0;
        n_acc++;
      end
    end
  endtask

  initial begin
    int pen_cnt, rto_cnt;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; PREADY = 1'b0; PRDATA = '0;
    n_acc = 0; n_drop = 0; dut_rsp = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (2) @(posedge PCLK);
    model_reset();
    hist_clear();

    // Reset state, command offered while reset is held is not accepted.
    step(1'b1, 32'd7, 1'b1, 32'h55, 1'b1, 1'b1);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("reset_ready", 32'(obs_ready), 32'd0);

    // Single write addr=1 data=120, no wait states.
    step(1'b1, 32'd1, 1'b1, 32'd120, 1'b1, 1'b0);
    hist_clear();
    repeat (4) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("single_psel", 32'(h_sel[3:0]), 32'b1100);
    chk("single_pen", 32'(h_en[3:0]), 32'b0100);
    chk("single_rv", 32'(h_rv[3:0]), 32'b0010);

    // Back-to-back writes with cmd_valid held high.
    step(1'b1, 32'd1, 1'b1, 32'd120, 1'b1, 1'b0);
    hist_clear();
    repeat (2) step(1'b1, 32'd2, 1'b1, 32'd5, 1'b1, 1'b0);
    repeat (2) step(1'b1, 32'd0, 1'b1, 32'd1, 1'b1, 1'b0);
    repeat (3) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("b2b_psel", 32'(h_sel[6:0]), 32'b1111110);
    chk("b2b_pen", 32'(h_en[6:0]), 32'b0101010);
    chk("b2b_rv", 32'(h_rv[6:0]), 32'b0010101);

    // Read with two wait states.
    mem[2] = 32'hA5A5_0005;
    step(1'b1, 32'd2, 1'b0, 32'd0, 1'b1, 1'b0);
    hist_clear();
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("wait_pen", 32'(h_en[4:0]), 32'b01110);
    chk("wait_rv", 32'(h_rv[4:0]), 32'b00001);
    chk("wait_rdata", obs_rdata, 32'hA5A5_0005);
    chk("wait_rto", 32'(obs_rto), 32'd0);

    // Reset in the second ACCESS cycle.
    step(1'b1, 32'd3, 1'b1, 32'd7, 1'b1, 1'b0);
    hist_clear();
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rst_mid_psel", 32'(obs_psel), 32'd0);
    chk("rst_mid_paddr", obs_paddr, 32'd0);
    chk("rst_mid_pwdata", obs_pwdata, 32'd0);
    chk("rst_mid_ready", 32'(obs_ready), 32'd1);
    repeat (2) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("rst_mid_norsp", 32'(h_rv[5:0]), 32'd0);

    // Command inputs changing during SETUP are ignored.
    step(1'b1, 32'd4, 1'b1, 32'd11, 1'b1, 1'b0);
    step(1'b1, 32'd9, 1'b1, 32'd99, 1'b1, 1'b0);
    chk("setup_ready", 32'(obs_ready), 32'd0);
    step(1'b0, 32'd9, 1'b1, 32'd99, 1'b0, 1'b0);
    chk("setup_hold_paddr", obs_paddr, 32'd4);
    step(1'b1, 32'd9, 1'b1, 32'd99, 1'b0, 1'b0);
    chk("access_busy_ready", 32'(obs_ready), 32'd0);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("access_hold_paddr", obs_paddr, 32'd4);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);

`ifdef APB_MASTER_TIMEOUT_EN
    // PREADY stuck low: abort after TO ACCESS cycles, then a normal write.
    step(1'b1, 32'd5, 1'b1, 32'd1, 1'b1, 1'b0);
    pen_cnt = 0; rto_cnt = 0;
    for (int c = 0; c < TO + 4; c++) begin
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
      if (obs_pen) pen_cnt++;
      if (obs_rv && obs_rto) rto_cnt++;
    end
    chk("timeout_access_cycles", 32'(pen_cnt), 32'(TO));
    chk("timeout_rsp", 32'(rto_cnt), 32'd1);
    step(1'b1, 32'd6, 1'b1, 32'd2, 1'b1, 1'b0);
    rto_cnt = 0; pen_cnt = 0;
    repeat (3) begin
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
      if (obs_rv) pen_cnt++;
      if (obs_rto) rto_cnt++;
    end
    chk("after_timeout_rsp", 32'(pen_cnt), 32'd1);
    chk("after_timeout_rto", 32'(rto_cnt), 32'd0);
`else
    pen_cnt = 0; rto_cnt = 0;
`endif

    // Randomized traffic with random wait states and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      step(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom,
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 199) == 0));
    end
    repeat (20) step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("rsp_count", 32'(dut_rsp), 32'(n_acc - n_drop));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

APB3 requester that turns a simple valid/ready command stream into APB transfers on the peripheral bus. It sits directly upstream of the APB_PWM slave and any other APB peripheral on the same bus. It drives PSEL/PENABLE/PADDR/PWRITE/PWDATA, waits on PREADY, and returns one response per command. It also supports back-to-back transfers with PSEL held high, which the PWM register setup sequence (period, duty, enable) uses.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort (used only with the timeout macro)

Ports:
- PCLK  in  1  bus clock; everything in this block is on its rising edge
- PRESET  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted on an edge where cmd_valid && cmd_ready
- cmd_addr  in  ADDR_W  target address
- cmd_write  in  1  1 = write, 0 = read
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle pulse, one per accepted command
- rsp_rdata  out  DATA_W  PRDATA captured on completion; 0 for writes and timeouts
- rsp_timeout  out  1  qualifies rsp_valid: transfer aborted
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  slave ready

## Operation
- FSM states: IDLE, SETUP, ACCESS. All APB outputs are registered.
- IDLE:
  - PSEL=0, PENABLE=0, cmd_ready=1.
  - On accept, latch cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA, then go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, cmd_ready=0.
  - Unconditionally go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - cmd_ready = PREADY, i.e. ready only in the completion cycle.
  - PREADY=0: stay in ACCESS, increment the wait counter.
  - PREADY=1 with no new command: complete, go to IDLE.
  - PREADY=1 with a new command accepted on the same edge: complete, latch the new command, go to SETUP with PSEL held 1 and PENABLE dropping to 0.
- Completion:
  - Next cycle, rsp_valid=1 and rsp_timeout=0.
  - rsp_rdata = PRDATA sampled on the completion edge for reads; 0 for writes.
- PADDR, PWRITE and PWDATA stay stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- The wait counter clears on entry to SETUP. It is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.

## Timing
- Reset values:
  - State IDLE.
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0.
  - rsp_valid, rsp_timeout = 0; rsp_rdata = 0.
  - cmd_ready=0 while PRESET is high.
- Accept on edge k:
  - SETUP during cycle k..k+1.
  - ACCESS from edge k+1.
  - With zero wait states, completion on edge k+2 and rsp_valid in cycle k+2..k+3.
- Throughput: an isolated transfer takes 3 cycles from accept to next accept; back-to-back transfers take 2 cycles per transfer.
- Each wait state (PREADY=0 in ACCESS) adds exactly 1 cycle.
- Simultaneous completion and new command: both are handled on the same edge, with no IDLE bubble.
- PRESET mid-transfer: on the next edge all outputs return to reset values and the FSM returns to IDLE. No response is generated for the in-flight command.
- cmd_valid held while busy: nothing is accepted, and command inputs are ignored until cmd_ready=1.

## Configuration
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - If the counter reaches TIMEOUT_CYCLES while PREADY=0 in ACCESS, abort on that edge.
  - PSEL and PENABLE go to 0 and the FSM goes to IDLE.
  - Next cycle, rsp_valid=1, rsp_timeout=1, rsp_rdata=0.
  - cmd_ready=0 in the abort cycle, so no back-to-back transfer follows a timeout.
- Undefined:
  - ACCESS waits indefinitely for PREADY.
  - rsp_timeout is tied to 0; the counter logic is absent.

## Test plan
- Single write, addr=1, data=120, PREADY=1: PSEL rises 1 cycle after accept, PENABLE 1 cycle later. PADDR=1 and PWDATA=120 are stable across both cycles. rsp_valid pulses once, rsp_rdata=0.
- Back-to-back writes (1,120), (2,5), (0,1), cmd_valid held high: PSEL stays 1 for 6 consecutive cycles and PENABLE toggles 0,1,0,1,0,1. Three rsp_valid pulses, then IDLE with PSEL=0.
- Read addr=2 with PREADY low for 2 ACCESS cycles, PRDATA=0xA5A5_0005: ACCESS lasts 3 cycles. rsp_rdata=0xA5A5_0005, rsp_timeout=0.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY stuck at 0: abort after 16 ACCESS cycles, PSEL falls to 0, rsp_valid=1 with rsp_timeout=1. The next command proceeds normally.
- PRESET asserted in the 2nd ACCESS cycle: all outputs are 0 on the following edge and no rsp_valid is produced. cmd_ready=1 one cycle after PRESET deasserts.
- cmd_valid toggling during SETUP with changed cmd_addr: PADDR keeps the originally latched value and cmd_ready stays 0.
